// File: rtl/fifo_stream_reader_pkg.sv
// Shared defaults and pointer-width helper for the FIFO stream reader and its skid buffer.
package fifo_stream_reader_pkg;

  localparam int DATA_LEN_DEF = 16;
  localparam int CNT_LEN_DEF  = 32;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buffer.sv
// Circular skid buffer: unreset storage, wrapping head/tail pointers and an occupancy count.
module skid_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int BUF_DEPTH = 2,
  localparam int PW = ptr_w(BUF_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [DATA_LEN-1:0] push_data,
  input  logic                pop,
  output logic [DATA_LEN-1:0] head_data,
  output logic [CW-1:0]       count
);

  logic [DATA_LEN-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;

  // Storage is deliberately left out of reset; the top masks the head when empty.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a non-showahead FIFO into a valid/ready stream through a small skid buffer.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_LEN   = CNT_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fifo_rd_empty,
  input  logic [DATA_LEN-1:0] fifo_data_out,
  output logic                fifo_rd_en,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_data,
  input  logic                out_ready,
  output logic [CNT_LEN-1:0]  words_delivered
);

  localparam int PW = ptr_w(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(BUF_DEPTH);

  logic                inflight;
  logic                pop;
  logic [CW-1:0]       count;
  logic [CW:0]         occ_next;
  logic [DATA_LEN-1:0] head_data;

  assign pop = out_valid & out_ready;

  // Occupancy after this edge if no new read were issued; count+inflight never exceeds depth.
  assign occ_next   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign fifo_rd_en = !reset && !fifo_rd_empty && (occ_next < DEPTH_V);

  // Read issued last cycle: FIFO data is on fifo_data_out now and is captured unconditionally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= fifo_rd_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    words_delivered <= '0;
    else if (pop) words_delivered <= words_delivered + 1'b1;
  end

  skid_buffer #(
    .DATA_LEN  (DATA_LEN),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head_data : '0;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: FIFO model feeds the reader, a negedge monitor checks every presented word.
module tb_fifo_stream_reader;

  localparam int DATA_LEN  = 16;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_LEN   = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                fifo_rd_empty = 1'b1;
  logic [DATA_LEN-1:0] fifo_data_out = '0;
  logic                fifo_rd_en;
  logic                out_valid;
  logic [DATA_LEN-1:0] out_data;
  logic                out_ready;
  logic [CNT_LEN-1:0]  words_delivered;

  logic                wr_en;
  logic [DATA_LEN-1:0] wr_data;
  logic [DATA_LEN-1:0] mq[$];
  logic [DATA_LEN-1:0] exp_q[$];
  int                  rd_cyc[$];
  int                  hs_cyc[$];
  int                  rd_total   = 0;
  int                  dlv_total  = 0;
  int                  discarded  = 0;
  int                  cyc        = 0;
  int                  vectors    = 0;
  int                  miscompares = 0;
  logic [CNT_LEN-1:0]  exp_wd = '0;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_LEN  (DATA_LEN),
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_LEN   (CNT_LEN)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fifo_rd_empty   (fifo_rd_empty),
    .fifo_data_out   (fifo_data_out),
    .fifo_rd_en      (fifo_rd_en),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .words_delivered (words_delivered)
  );

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Behavioural dcfifo, showahead off: read data appears the cycle after the request.
  always @(posedge clk) begin
    if (fifo_rd_en && mq.size() > 0) begin
      fifo_data_out <= mq.pop_front();
      rd_total++;
    end
    if (wr_en) mq.push_back(wr_data);
    fifo_rd_empty <= (mq.size() == 0);
  end

  // Monitor: handshake decided here completes at the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_words_delivered", words_delivered, 0);
      check("reset_rd_en", fifo_rd_en, 0);
      exp_wd = '0;
    end else begin
      check("rd_en_while_empty", fifo_rd_en & fifo_rd_empty, 0);
      check("words_delivered", words_delivered, exp_wd);
      check("occupancy_le_depth", (rd_total - dlv_total - discarded) <= BUF_DEPTH, 1);
      if (fifo_rd_en) rd_cyc.push_back(cyc);
      if (!out_valid) begin
        check("idle_out_data_zero", out_data, 0);
      end else if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: actual 0x%0h required none", out_data);
      end else begin
        check("out_data_order", out_data, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          hs_cyc.push_back(cyc);
          dlv_total++;
          exp_wd++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DATA_LEN-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drop;
    int sent;
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_data   = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("init_out_valid", out_valid, 0);
    check("init_words_delivered", words_delivered, 0);
    reset = 1'b0;
    tick();

    // Latency: four words back to back, consumer always ready.
    rd_cyc.delete();
    hs_cyc.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) write_word(DATA_LEN'(i));
    wait_drain(30, "latency");
    check("lat_rd_pulses", rd_cyc.size(), 4);
    check("lat_words", hs_cyc.size(), 4);
    if (rd_cyc.size() >= 4) check("lat_rd_consecutive", rd_cyc[3] - rd_cyc[0], 3);
    if (hs_cyc.size() >= 4 && rd_cyc.size() >= 1) begin
      check("lat_first_out", hs_cyc[0] - rd_cyc[0], 2);
      check("lat_out_consecutive", hs_cyc[3] - hs_cyc[0], 3);
    end
    check("lat_words_delivered", words_delivered, 4);

    // Backpressure: eight words queued, consumer stalled.
    rd_cyc.delete();
    hs_cyc.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) write_word(DATA_LEN'(i));
    repeat (10) tick();
    check("bp_rd_pulses", rd_cyc.size(), BUF_DEPTH);
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data", out_data, 16'h0001);
      tick();
    end
    out_ready = 1'b1;
    wait_drain(60, "bp");
    check("bp_words_delivered", words_delivered, 12);

    // Empty boundary: FIFO empties the cycle its only word is read.
    rd_cyc.delete();
    hs_cyc.delete();
    write_word(16'h00a5);
    wait_drain(20, "empty_boundary");
    check("eb_rd_pulses", rd_cyc.size(), 1);
    check("eb_delivered", hs_cyc.size(), 1);

    // Counter wrap: seventeen handshakes on a 4-bit counter.
    for (int i = 0; i < 4; i++) write_word(16'h0b00 + DATA_LEN'(i));
    wait_drain(30, "wrap");
    check("wrap_17_handshakes", words_delivered, 1);

    // Mid-run reset with one word buffered and one in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(16'h0100 + DATA_LEN'(i));
    repeat (6) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_words_delivered", words_delivered, 0);
    check("async_rst_rd_en", fifo_rd_en, 0);
    drop = rd_total - dlv_total - discarded;
    check("rst_words_held", drop, 2);
    for (int i = 0; i < drop; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
    discarded += drop;
    repeat (3) tick();
    check("rst_fifo_not_empty", fifo_rd_empty, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    wait_drain(60, "post_reset");

    // Random traffic: 1000 words, random writes and random consumer stalls.
    sent = 0;
    while (sent < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        wr_en   = 1'b1;
        wr_data = DATA_LEN'($urandom);
        exp_q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en     = 1'b0;
    out_ready = 1'b1;
    wait_drain(3000, "random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
